// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl opcodes, default datapath width, requester id.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int REQ_ID_W   = 1;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SRL  = 4'b0100,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_ADDU = 4'b1000,
    ALU_SUBU = 4'b1001,
    ALU_XOR  = 4'b1010,
    ALU_SLTU = 4'b1011,
    ALU_NOR  = 4'b1100,
    ALU_SRA  = 4'b1101,
    ALU_LUI  = 4'b1110
  } alu_op_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Team combinational ALU; shifts take the amount from bus_a, unknown codes give 0.
module alu_share_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] bus_a,
  input  logic [DATA_W-1:0] bus_b,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;

  assign shamt = bus_a[SH_W-1:0];

  always_comb begin
    alu_out = '0;
    unique case (alu_ctrl)
      ALU_AND:  alu_out = bus_a & bus_b;
      ALU_OR:   alu_out = bus_a | bus_b;
      ALU_ADD:  alu_out = bus_a + bus_b;
      ALU_ADDU: alu_out = bus_a + bus_b;
      ALU_SUB:  alu_out = bus_a - bus_b;
      ALU_SUBU: alu_out = bus_a - bus_b;
      ALU_SLL:  alu_out = bus_b << shamt;
      ALU_SRL:  alu_out = bus_b >> shamt;
      ALU_SRA:  alu_out = $signed(bus_b) >>> shamt;
      ALU_SLT:  alu_out = DATA_W'($signed(bus_a) < $signed(bus_b));
      ALU_SLTU: alu_out = DATA_W'(bus_a < bus_b);
      ALU_XOR:  alu_out = bus_a ^ bus_b;
      ALU_NOR:  alu_out = ~(bus_a | bus_b);
      ALU_LUI:  alu_out = bus_b << 16;
      default:  alu_out = '0;
    endcase
  end

  assign zero = (alu_out == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester ALU arbiter: priority to req 0 with aging for req 1, 2-stage pipe.
// Define ALU_ARB_PERF_EN to add Gnt0Cnt/Gnt1Cnt/ConflictCnt counters.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W   = ALU_DATA_W,
  parameter int MAX_WAIT = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Req0,
  input  logic [3:0]        Op0,
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] B0,
  output logic              Gnt0,
  input  logic              Req1,
  input  logic [3:0]        Op1,
  input  logic [DATA_W-1:0] A1,
  input  logic [DATA_W-1:0] B1,
  output logic              Gnt1,
  output logic              RespValid0,
  output logic              RespValid1,
  output logic [DATA_W-1:0] Result,
  output logic              Zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]       Gnt0Cnt,
  output logic [31:0]       Gnt1Cnt,
  output logic [31:0]       ConflictCnt
`endif
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt;
  logic              age_win;
  logic              iss_valid;
  req_id_t           iss_id;
  logic [3:0]        iss_op;
  logic [DATA_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_b;
  logic              res_valid;
  req_id_t           res_id;
  logic [DATA_W-1:0] alu_y;
  logic              alu_zero_unused;

  // Aged requester 1 overrides the fixed priority of requester 0.
  assign age_win = Req1 && (wait_cnt == MAX_W);
  assign Gnt1 = !Reset && !Stall && Req1 && (age_win || !Req0);
  assign Gnt0 = !Reset && !Stall && Req0 && !age_win;

  assign RespValid0 = !Reset && !Stall && res_valid && (res_id == 1'b0);
  assign RespValid1 = !Reset && !Stall && res_valid && (res_id == 1'b1);

  alu_share_arbiter_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .alu_ctrl(iss_op),
    .bus_a   (iss_a),
    .bus_b   (iss_b),
    .alu_out (alu_y),
    .zero    (alu_zero_unused)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      iss_valid <= 1'b0;
      iss_id    <= '0;
      iss_op    <= '0;
      iss_a     <= '0;
      iss_b     <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      Result    <= '0;
      Zero      <= 1'b0;
      wait_cnt  <= '0;
    end else if (!Stall) begin
      iss_valid <= Gnt0 || Gnt1;
      if (Gnt0 || Gnt1) begin
        iss_id <= Gnt1;
        iss_op <= Gnt1 ? Op1 : Op0;
        iss_a  <= Gnt1 ? A1 : A0;
        iss_b  <= Gnt1 ? B1 : B0;
      end
      res_valid <= iss_valid;
      if (iss_valid) begin
        res_id <= iss_id;
        Result <= alu_y;
        Zero   <= (alu_y == '0);
      end
      if (Gnt1 || !Req1) begin
        wait_cnt <= '0;
      end else if (wait_cnt != MAX_W) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Gnt0Cnt     <= '0;
      Gnt1Cnt     <= '0;
      ConflictCnt <= '0;
    end else if (!Stall) begin
      if (Gnt0) Gnt0Cnt <= Gnt0Cnt + 32'd1;
      if (Gnt1) Gnt1Cnt <= Gnt1Cnt + 32'd1;
      if (Req0 && Req1) ConflictCnt <= ConflictCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_alu_share_arbiter;

  localparam int MW = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        Req0 = 1'b0;
  logic [3:0]  Op0 = '0;
  logic [31:0] A0 = '0;
  logic [31:0] B0 = '0;
  logic        Gnt0;
  logic        Req1 = 1'b0;
  logic [3:0]  Op1 = '0;
  logic [31:0] A1 = '0;
  logic [31:0] B1 = '0;
  logic        Gnt1;
  logic        RespValid0;
  logic        RespValid1;
  logic [31:0] Result;
  logic        Zero;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] gnt0_cnt;
  logic [31:0] gnt1_cnt;
  logic [31:0] conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] r;
    int          age;
  } rsp_t;

  alu_share_arbiter #(
    .DATA_W(32),
    .MAX_WAIT(MW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .Req0(Req0), .Op0(Op0), .A0(A0), .B0(B0), .Gnt0(Gnt0),
    .Req1(Req1), .Op1(Op1), .A1(A1), .B1(B1), .Gnt1(Gnt1),
    .RespValid0(RespValid0), .RespValid1(RespValid1),
    .Result(Result), .Zero(Zero)
`ifdef ALU_ARB_PERF_EN
    , .Gnt0Cnt(gnt0_cnt), .Gnt1Cnt(gnt1_cnt), .ConflictCnt(conflict_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int sh;
    sh = int'(a[4:0]);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010, 4'b1000: return a + b;
      4'b0110, 4'b1001: return a - b;
      4'b0011: return b << sh;
      4'b0100: return b >> sh;
      4'b1101: return $signed(b) >>> sh;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1011: return (a < b) ? 32'd1 : 32'd0;
      4'b1010: return a ^ b;
      4'b1100: return ~(a | b);
      4'b1110: return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 8));
    return $urandom;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Req0 = 1'b0;
    Req1 = 1'b0;
    Stall = 1'b0;
  endtask

  task automatic test_reset();
    Req0 = 1'b1;
    Req1 = 1'b1;
    @(negedge Clk);
    checks++; if (Gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got %b exp 0", Gnt0); end
    checks++; if (Gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1 got %b exp 0", Gnt1); end
    checks++; if (RespValid0 !== 1'b0) begin errors++; $display("FAIL rst_rv0 got %b exp 0", RespValid0); end
    checks++; if (RespValid1 !== 1'b0) begin errors++; $display("FAIL rst_rv1 got %b exp 0", RespValid1); end
    checks++; if (Result !== 32'd0) begin errors++; $display("FAIL rst_result got %h exp 0", Result); end
    checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL rst_zero got %b exp 0", Zero); end
    tick();
    Reset = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_single_op();
    Req0 = 1'b1; Op0 = 4'b0010; A0 = 32'd5; B0 = 32'd7;
    @(negedge Clk);
    checks++; if (Gnt0 !== 1'b1) begin errors++; $display("FAIL single_gnt0 got %b exp 1", Gnt0); end
    tick();
    Req0 = 1'b0;
    @(negedge Clk);
    checks++; if (RespValid0 !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", RespValid0); end
    tick();
    @(negedge Clk);
    checks++; if (RespValid0 !== 1'b1) begin errors++; $display("FAIL single_rv0 got %b exp 1", RespValid0); end
    checks++; if (RespValid1 !== 1'b0) begin errors++; $display("FAIL single_rv1 got %b exp 0", RespValid1); end
    checks++; if (Result !== 32'd12) begin errors++; $display("FAIL single_result got %h exp c", Result); end
    checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL single_zero got %b exp 0", Zero); end
    tick();
    @(negedge Clk);
    checks++; if (RespValid0 !== 1'b0) begin errors++; $display("FAIL single_once got %b exp 0", RespValid0); end
    tick();
  endtask

  task automatic test_back_to_back();
    Req0 = 1'b1; Op0 = 4'b0110; A0 = 32'd9; B0 = 32'd9;
    @(negedge Clk);
    checks++; if (Gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_gnt0 got %b exp 1", Gnt0); end
    tick();
    Req0 = 1'b0;
    Req1 = 1'b1; Op1 = 4'b1011; A1 = 32'd1; B1 = 32'hFFFF_FFFF;
    @(negedge Clk);
    checks++; if (Gnt1 !== 1'b1) begin errors++; $display("FAIL b2b_gnt1 got %b exp 1", Gnt1); end
    tick();
    Req1 = 1'b0;
    @(negedge Clk);
    checks++; if (RespValid0 !== 1'b1) begin errors++; $display("FAIL b2b_rv0 got %b exp 1", RespValid0); end
    checks++; if (Result !== 32'd0) begin errors++; $display("FAIL b2b_res0 got %h exp 0", Result); end
    checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL b2b_zero0 got %b exp 1", Zero); end
    tick();
    @(negedge Clk);
    checks++; if (RespValid1 !== 1'b1) begin errors++; $display("FAIL b2b_rv1 got %b exp 1", RespValid1); end
    checks++; if (RespValid0 !== 1'b0) begin errors++; $display("FAIL b2b_rv0_off got %b exp 0", RespValid0); end
    checks++; if (Result !== 32'd1) begin errors++; $display("FAIL b2b_res1 got %h exp 1", Result); end
    checks++; if (Zero !== 1'b0) begin errors++; $display("FAIL b2b_zero1 got %b exp 0", Zero); end
    tick();
  endtask

  task automatic test_aging();
    logic e1;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] c0;
    c0 = conflict_cnt;
`endif
    Req0 = 1'b1; Op0 = 4'b0010; A0 = 32'd1; B0 = 32'd1;
    Req1 = 1'b1; Op1 = 4'b0010; A1 = 32'd2; B1 = 32'd2;
    for (int i = 0; i < 8; i++) begin
      e1 = ((i % (MW + 1)) == MW);
      @(negedge Clk);
      checks++; if (Gnt1 !== e1) begin errors++; $display("FAIL aging_gnt1[%0d] got %b exp %b", i, Gnt1, e1); end
      checks++; if (Gnt0 !== !e1) begin errors++; $display("FAIL aging_gnt0[%0d] got %b exp %b", i, Gnt0, !e1); end
      tick();
    end
    idle();
`ifdef ALU_ARB_PERF_EN
    @(negedge Clk);
    checks++; if (conflict_cnt - c0 !== 32'd8) begin errors++; $display("FAIL aging_conflict got %0d exp 8", conflict_cnt - c0); end
`endif
    repeat (3) tick();
  endtask

  task automatic test_stall();
    Req0 = 1'b1; Op0 = 4'b0011; A0 = 32'd4; B0 = 32'd1;
    @(negedge Clk);
    checks++; if (Gnt0 !== 1'b1) begin errors++; $display("FAIL stall_gnt0 got %b exp 1", Gnt0); end
    tick();
    Req0 = 1'b0;
    @(negedge Clk);
    checks++; if (RespValid0 !== 1'b0) begin errors++; $display("FAIL stall_early got %b exp 0", RespValid0); end
    tick();
    Stall = 1'b1;
    Req1 = 1'b1; Op1 = 4'b0010; A1 = 32'd1; B1 = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++; if (RespValid0 !== 1'b0) begin errors++; $display("FAIL stall_rv0[%0d] got %b exp 0", i, RespValid0); end
      checks++; if (Gnt1 !== 1'b0) begin errors++; $display("FAIL stall_gnt1[%0d] got %b exp 0", i, Gnt1); end
      tick();
    end
    Stall = 1'b0;
    Req1 = 1'b0;
    @(negedge Clk);
    checks++; if (RespValid0 !== 1'b1) begin errors++; $display("FAIL stall_rel_rv0 got %b exp 1", RespValid0); end
    checks++; if (Result !== 32'd16) begin errors++; $display("FAIL stall_result got %h exp 10", Result); end
    tick();
    @(negedge Clk);
    checks++; if (RespValid0 !== 1'b0) begin errors++; $display("FAIL stall_once got %b exp 0", RespValid0); end
    tick();
  endtask

  task automatic test_reset_mid();
    Req0 = 1'b1; Op0 = 4'b0001; A0 = 32'hF0; B0 = 32'h0F;
    @(negedge Clk);
    checks++; if (Gnt0 !== 1'b1) begin errors++; $display("FAIL rmid_gnt0 got %b exp 1", Gnt0); end
    tick();
    Req0 = 1'b0;
    Reset = 1'b1;
    #1;
    checks++; if (Result !== 32'd0) begin errors++; $display("FAIL rmid_result got %h exp 0", Result); end
    checks++; if (RespValid0 !== 1'b0) begin errors++; $display("FAIL rmid_rv0 got %b exp 0", RespValid0); end
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++; if (RespValid0 !== 1'b0) begin errors++; $display("FAIL rmid_post_rv0[%0d] got %b exp 0", i, RespValid0); end
      checks++; if (RespValid1 !== 1'b0) begin errors++; $display("FAIL rmid_post_rv1[%0d] got %b exp 0", i, RespValid1); end
      tick();
    end
    Req0 = 1'b1; Op0 = 4'b0010; A0 = 32'd1; B0 = 32'd2;
    @(negedge Clk);
    checks++; if (Gnt0 !== 1'b1) begin errors++; $display("FAIL rmid_fresh_gnt got %b exp 1", Gnt0); end
    tick();
    Req0 = 1'b0;
    tick();
    @(negedge Clk);
    checks++; if (RespValid0 !== 1'b1) begin errors++; $display("FAIL rmid_fresh_rv got %b exp 1", RespValid0); end
    checks++; if (Result !== 32'd3) begin errors++; $display("FAIL rmid_fresh_res got %h exp 3", Result); end
    tick();
  endtask

  task automatic test_unknown_op();
    Req1 = 1'b1; Op1 = 4'b0101; A1 = 32'd3; B1 = 32'd3;
    @(negedge Clk);
    checks++; if (Gnt1 !== 1'b1) begin errors++; $display("FAIL unk_gnt1 got %b exp 1", Gnt1); end
    tick();
    Req1 = 1'b0;
    tick();
    @(negedge Clk);
    checks++; if (RespValid1 !== 1'b1) begin errors++; $display("FAIL unk_rv1 got %b exp 1", RespValid1); end
    checks++; if (Result !== 32'd0) begin errors++; $display("FAIL unk_result got %h exp 0", Result); end
    checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL unk_zero got %b exp 1", Zero); end
    tick();
  endtask

  task automatic test_random();
    rsp_t q[$];
    rsp_t item;
    int   wc;
    bit   p0, p1, eg0, eg1, e0, e1;
    logic [31:0] er;
    logic [3:0]  o0, o1;
    logic [31:0] a0, b0, a1, b1;
    wc = 0; p0 = 0; p1 = 0; er = '0;
    o0 = '0; o1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    idle();
    for (int n = 0; n < 400; n++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1; o0 = 4'($urandom_range(0, 15)); a0 = rnd_val(); b0 = rnd_val();
      end else if (p0 && $urandom_range(0, 19) == 0) begin
        p0 = 0;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; o1 = 4'($urandom_range(0, 15)); a1 = rnd_val(); b1 = rnd_val();
      end else if (p1 && $urandom_range(0, 19) == 0) begin
        p1 = 0;
      end
      Req0 = p0; Op0 = o0; A0 = a0; B0 = b0;
      Req1 = p1; Op1 = o1; A1 = a1; B1 = b1;
      Stall = ($urandom_range(0, 4) == 0);
      @(negedge Clk);
      eg1 = !Stall && p1 && (wc == MW || !p0);
      eg0 = !Stall && p0 && !eg1;
      checks++; if (Gnt0 !== eg0) begin errors++; $display("FAIL rnd_gnt0[%0d] got %b exp %b", n, Gnt0, eg0); end
      checks++; if (Gnt1 !== eg1) begin errors++; $display("FAIL rnd_gnt1[%0d] got %b exp %b", n, Gnt1, eg1); end
      e0 = 0; e1 = 0;
      foreach (q[i]) begin
        if (q[i].age == 2 && !Stall) begin
          if (q[i].id == 0) e0 = 1; else e1 = 1;
          er = q[i].r;
        end
      end
      checks++; if (RespValid0 !== e0) begin errors++; $display("FAIL rnd_rv0[%0d] got %b exp %b", n, RespValid0, e0); end
      checks++; if (RespValid1 !== e1) begin errors++; $display("FAIL rnd_rv1[%0d] got %b exp %b", n, RespValid1, e1); end
      if (e0 || e1) begin
        checks++; if (Result !== er) begin errors++; $display("FAIL rnd_result[%0d] got %h exp %h", n, Result, er); end
        checks++; if (Zero !== (er == 32'd0)) begin errors++; $display("FAIL rnd_zero[%0d] got %b exp %b", n, Zero, er == 32'd0); end
      end
      @(posedge Clk);
      if (!Stall) begin
        foreach (q[i]) q[i].age++;
        q = q.find(x) with (x.age <= 2);
        if (eg0) begin item.id = 0; item.r = alu_ref(o0, a0, b0); item.age = 1; q.push_back(item); end
        if (eg1) begin item.id = 1; item.r = alu_ref(o1, a1, b1); item.age = 1; q.push_back(item); end
        if (eg1 || !p1) wc = 0;
        else if (wc < MW) wc++;
      end
      if (eg0) p0 = 0;
      if (eg1) p1 = 0;
      #1;
    end
    idle();
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_back_to_back();
    test_aging();
    test_stall();
    test_reset_mid();
    test_unknown_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit combinational ALU between two requesters:
  - Req 0: pipeline EX stage.
  - Req 1: secondary unit, e.g. branch-target or address calculator.
- Fixed priority to requester 0, with aging so requester 1 cannot starve.
- Sequences each granted op through a 2-stage registered pipeline (issue, result).
- Returns the result and zero flag tagged to the originating requester.
- Sits between the decode/EX control and the existing team ALU (4-bit ALUCtrl encoding).

Parameters:
- DATA_W, 32: operand/result width. Must equal ALU width.
- MAX_WAIT, 3: cycles requester 1 may be denied while requesting before it is forced to win. Legal range 1..15.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Stall  in  1  freezes the arbiter and pipeline.
- Req0  in  1  requester 0 has an op pending.
- Op0  in  4  requester 0 ALUCtrl code.
- A0  in  DATA_W  requester 0 BusA operand (shamt for shifts).
- B0  in  DATA_W  requester 0 BusB operand.
- Gnt0  out  1  combinational grant; op captured this cycle.
- Req1, Op1, A1, B1, Gnt1  same for requester 1.
- RespValid0  out  1  Result/Zero belong to requester 0 this cycle.
- RespValid1  out  1  Result/Zero belong to requester 1 this cycle.
- Result  out  DATA_W  registered ALU result.
- Zero  out  1  registered zero flag (Result == 0).

Behaviour:
- Reset (async, immediate):
  - Issue and result valid bits cleared; Gnt0/Gnt1/RespValid0/RespValid1 = 0.
  - Result = 0, Zero = 0, WaitCnt = 0.
  - In-flight ops are discarded, not replayed.
- Grant (combinational, cycle T):
  - Stall = 1: no grant.
  - Else if Req1 && WaitCnt == MAX_WAIT: Gnt1.
  - Else if Req0: Gnt0.
  - Else if Req1: Gnt1.
  - At most one grant per cycle. Gnt0 and Gnt1 are never both 1.
- Handshake:
  - Requester holds Req/Op/A/B stable until it sees Gnt high at a clock edge.
  - Dropping Req without a grant is legal; nothing is issued.
  - Back-to-back grants to the same requester are allowed, so throughput is 1 op/cycle.
- Pipeline:
  - Edge ending T: the issue register captures {Op, A, B, requester id, valid}.
  - Cycle T+1: the ALU evaluates the issue register.
  - Edge ending T+1: the result register captures {Result, Zero, id, valid}.
  - Cycle T+2: RespValid[id] = 1 for exactly one cycle. Latency is 2 cycles, grant to response.
- Stall = 1:
  - All registers and WaitCnt hold.
  - RespValid0/RespValid1 forced 0; Result/Zero hold.
  - The pending response is presented on the first cycle after Stall deasserts.
- WaitCnt (0..MAX_WAIT, saturating):
  - Clears on Gnt1 or when Req1 = 0.
  - Increments when Req1 && !Gnt1 && !Stall.
  - Saturates at MAX_WAIT; it never wraps.
- Zero is computed from the registered Result, never from unissued data.
- Unknown Op codes follow ALU default behaviour: Result = 0, Zero = 1.
- Reset asserted mid-stream: no RespValid from pre-reset ops, ever.

Optional Feature:
- Macro ALU_ARB_PERF_EN.
- When defined, adds outputs:
  - Gnt0Cnt (32): increments per Gnt0.
  - Gnt1Cnt (32): increments per Gnt1.
  - ConflictCnt (32): increments per non-stalled cycle with Req0 && Req1.
- All three counters are cleared by Reset, wrap modulo 2^32, and hold during Stall.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, ADDU 1000, SUBU 1001, XOR 1010, SLTU 1011, NOR 1100, SRA 1101, LUI 1110.
  - DATA_W default and requester-id width.
- One sub-module instance: the existing team ALU, driven from the issue register. Its Zero output is not used; the registered Zero is the output.
- The arbiter logic, WaitCnt and both pipeline registers stay in this module.

Test Plan:
- Single op: Req0=1, Op0=ADD, A0=5, B0=7 for 1 cycle → Gnt0 same cycle; 2 cycles later RespValid0=1, Result=12, Zero=0; RespValid1 stays 0.
- Conflict and aging (MAX_WAIT=3): Req0 and Req1 held continuously → grant sequence 0,0,0,1,0,0,0,1…; ConflictCnt increments every cycle if ALU_ARB_PERF_EN.
- Back-to-back mixed:
  - Stimulus: Gnt0 SUB 9-9, then Gnt1 SLTU A1=1, B1=0xFFFFFFFF.
  - Response cycle 1: RespValid0, Result=0, Zero=1.
  - Response next cycle: RespValid1, Result=1, Zero=0.
- Stall mid-flight: issue SLL A0=4, B0=1, then Stall=1 for 3 cycles → no RespValid, no grants during Stall; first cycle after release RespValid0, Result=16.
- Reset mid-operation: grant OR op, assert Reset the next cycle → outputs zero immediately; no RespValid after release; first post-reset grant behaves as fresh.
- Unknown opcode: Op1=0101, A1=3, B1=3 → RespValid1, Result=0, Zero=1.
